// File: rtl/warp_imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : warp_imem_arbiter_if
// Description : Request/response bundle between the fetch unit, the load unit,
//               the shared memory read port and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface warp_imem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  i_imem_ren;
    logic [ADDR_WIDTH-1:0] i_imem_raddr;
    logic                  o_imem_valid;
    logic [DATA_WIDTH-1:0] o_imem_rdata;

    logic                  i_dmem_ren;
    logic [ADDR_WIDTH-1:0] i_dmem_raddr;
    logic                  o_dmem_valid;
    logic [DATA_WIDTH-1:0] o_dmem_rdata;

    logic                  o_mem_ren;
    logic [ADDR_WIDTH-1:0] o_mem_raddr;
    logic                  i_mem_valid;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    logic                  o_busy;

    // Arbiter side
    modport master (
        input  i_imem_ren, i_imem_raddr,
        input  i_dmem_ren, i_dmem_raddr,
        input  i_mem_valid, i_mem_rdata,
        output o_imem_valid, o_imem_rdata,
        output o_dmem_valid, o_dmem_rdata,
        output o_mem_ren, o_mem_raddr,
        output o_busy
    );

    // Requesters and memory side
    modport slave (
        output i_imem_ren, i_imem_raddr,
        output i_dmem_ren, i_dmem_raddr,
        output i_mem_valid, i_mem_rdata,
        input  o_imem_valid, o_imem_rdata,
        input  o_dmem_valid, o_dmem_rdata,
        input  o_mem_ren, o_mem_raddr,
        input  o_busy
    );
endinterface
`default_nettype wire

// File: rtl/warp_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : warp_imem_arbiter
// Description : Round-robin arbiter sharing one memory read port between
//               instruction fetch (req 0) and the load unit (req 1).
// Revision    : 1.0 - initial release
// ============================================================================
module warp_imem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    warp_imem_arbiter_if.master   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic c_REQ_FETCH = 1'b0;
    localparam logic c_REQ_LOAD  = 1'b1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner;
    logic                  w_owner_nxt;
    logic                  r_last_grant;
    logic                  w_last_grant_nxt;

    logic [1:0]            r_slot_vld;
    logic [ADDR_WIDTH-1:0] r_slot_addr [2];

    logic [1:0]            w_ren;
    logic [ADDR_WIDTH-1:0] w_in_addr [2];
    logic [1:0]            w_cand;
    logic                  w_free;
    logic                  w_resp;
    logic                  w_grant;
    logic                  w_winner;
    logic [1:0]            w_grant_vec;
    logic [ADDR_WIDTH-1:0] w_grant_addr;

    assign w_ren        = {bus.i_dmem_ren, bus.i_imem_ren};
    assign w_in_addr[0] = bus.i_imem_raddr;
    assign w_in_addr[1] = bus.i_dmem_raddr;

    // Grant, routing and next-state decode
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_grant          = 1'b0;
        w_grant_addr     = '0;
        w_cand           = r_slot_vld | w_ren;
        // Gating with i_rst_n keeps every output low while reset is held
        w_free           = i_rst_n && ((r_state == ST_IDLE) || bus.i_mem_valid);
        w_resp           = i_rst_n && (r_state == ST_BUSY) && bus.i_mem_valid;

        if (w_cand == 2'b11) begin
            w_winner = ~r_last_grant;
        end else begin
            w_winner = w_cand[1];
        end

        if (w_free && (|w_cand)) begin
            w_grant          = 1'b1;
            w_grant_addr     = r_slot_vld[w_winner] ? r_slot_addr[w_winner]
                                                    : w_in_addr[w_winner];
            w_state_nxt      = ST_BUSY;
            w_owner_nxt      = w_winner;
            w_last_grant_nxt = w_winner;
        end else if (w_resp) begin
            w_state_nxt = ST_IDLE;
        end

        w_grant_vec = {w_grant & w_winner, w_grant & ~w_winner};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= c_REQ_FETCH;
            r_last_grant <= c_REQ_LOAD;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // A request that loses arbitration (or arrives while busy) parks here
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_slot_vld[gi]  <= 1'b0;
                    r_slot_addr[gi] <= '0;
                end else if (w_grant_vec[gi]) begin
                    r_slot_vld[gi]  <= 1'b0;
                end else if (w_ren[gi]) begin
                    r_slot_vld[gi]  <= 1'b1;
                    r_slot_addr[gi] <= w_in_addr[gi];
                end
            end
        end
    endgenerate

    assign bus.o_mem_ren    = w_grant;
    assign bus.o_mem_raddr  = w_grant_addr;
    assign bus.o_busy       = (r_state == ST_BUSY);

    assign bus.o_imem_valid = w_resp && (r_owner == c_REQ_FETCH);
    assign bus.o_dmem_valid = w_resp && (r_owner == c_REQ_LOAD);
    assign bus.o_imem_rdata = bus.o_imem_valid ? bus.i_mem_rdata : {DATA_WIDTH{1'b0}};
    assign bus.o_dmem_rdata = bus.o_dmem_valid ? bus.i_mem_rdata : {DATA_WIDTH{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_warp_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_warp_imem_arbiter
// Description : Directed vector table plus a randomised requester/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_warp_imem_arbiter;

    localparam logic [63:0] c_A    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_D    = 64'h0000_0013_0000_0013;
    localparam logic [63:0] c_MASK = 64'hA5A5_5A5A_0F0F_F0F0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    warp_imem_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    warp_imem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    typedef struct {
        logic        rst_n;
        logic        iren;
        logic [63:0] iaddr;
        logic        dren;
        logic [63:0] daddr;
        logic        mv;
        logic [63:0] md;
        logic        e_mren;
        logic [63:0] e_maddr;
        logic        e_iv;
        logic [63:0] e_id;
        logic        e_dv;
        logic [63:0] e_dd;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [63:0] ia,
        input logic dr, input logic [63:0] da, input logic mv, input logic [63:0] md,
        input logic emr, input logic [63:0] ema, input logic eiv, input logic [63:0] eid,
        input logic edv, input logic [63:0] edd, input logic eb);
        vec_t v;
        v.rst_n = r;   v.iren = ir;  v.iaddr = ia; v.dren = dr; v.daddr = da;
        v.mv = mv;     v.md = md;
        v.e_mren = emr; v.e_maddr = ema; v.e_iv = eiv; v.e_id = eid;
        v.e_dv = edv;  v.e_dd = edd; v.e_busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.i_imem_ren = 1'b0; bus.i_imem_raddr = '0;
        bus.i_dmem_ren = 1'b0; bus.i_dmem_raddr = '0;
        bus.i_mem_valid = 1'b0; bus.i_mem_rdata = '0;
    endtask

    // Random-phase models
    logic        inflight [2];
    logic [63:0] req_addr [2];
    int          wait_cnt [2];
    logic        mem_pend;
    logic [63:0] mem_addr;
    int          mem_cnt;
    logic        mv_now;

    initial begin
        drive_idle();

        // reset with live inputs: everything must stay low
        tbl.push_back(mk(0, 1, c_A, 1, 64'h2000, 1, c_D,        0, 0, 0, 0, 0, 0, 0));
        // fetch-only stream, re-request on every valid
        tbl.push_back(mk(1, 1, c_A, 0, 0, 0, 0,                 1, c_A, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, c_A, 0, 0, 1, c_D,               1, c_A, 1, c_D, 0, 0, 1));
        tbl.push_back(mk(1, 1, c_A, 0, 0, 1, c_D,               1, c_A, 1, c_D, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, c_D,                 0, 0, 1, c_D, 0, 0, 1));
        // spurious valid while idle
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'hDEAD,            0, 0, 0, 0, 0, 0, 0));
        // simultaneous first request after reset
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 64'h1000, 1, 64'h2000, 0, 0,     1, 64'h1000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'h11,              1, 64'h2000, 1, 64'h11, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'h22,              0, 0, 0, 0, 1, 64'h22, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0));
        // continuous contention, 8 transactions alternating
        tbl.push_back(mk(1, 1, 64'h100, 1, 64'h200, 0, 0,       1, 64'h100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 64'h108, 0, 0, 1, 64'hD1,        1, 64'h200, 1, 64'hD1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 64'h208, 1, 64'hD2,        1, 64'h108, 0, 0, 1, 64'hD2, 1));
        tbl.push_back(mk(1, 1, 64'h110, 0, 0, 1, 64'hD3,        1, 64'h208, 1, 64'hD3, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 64'h210, 1, 64'hD4,        1, 64'h110, 0, 0, 1, 64'hD4, 1));
        tbl.push_back(mk(1, 1, 64'h118, 0, 0, 1, 64'hD5,        1, 64'h210, 1, 64'hD5, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 64'h218, 1, 64'hD6,        1, 64'h118, 0, 0, 1, 64'hD6, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'hD7,              1, 64'h218, 1, 64'hD7, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'hD8,              0, 0, 0, 0, 1, 64'hD8, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0));
        // load arrives during a 3-cycle fetch, issues on the fetch response
        tbl.push_back(mk(1, 1, 64'h80, 0, 0, 0, 0,              1, 64'h80, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 64'h40, 0, 0,              0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'hE1,              1, 64'h40, 1, 64'hE1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'hE2,              0, 0, 0, 0, 1, 64'hE2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0));
        // reset mid-transaction, then a stale response
        tbl.push_back(mk(1, 1, 64'h300, 0, 0, 0, 0,             1, 64'h300, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 64'h308, 1, 64'h408, 1, 64'hF1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'hF1,              0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 64'h400, 0, 0, 0, 0,             1, 64'h400, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'hF2,              0, 0, 1, 64'hF2, 0, 0, 1));
        // lone load request bypasses
        tbl.push_back(mk(1, 0, 0, 1, 64'h500, 0, 0,             1, 64'h500, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 64'hF3,              0, 0, 0, 0, 1, 64'hF3, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            rst_n            = tbl[i].rst_n;
            bus.i_imem_ren   = tbl[i].iren;  bus.i_imem_raddr = tbl[i].iaddr;
            bus.i_dmem_ren   = tbl[i].dren;  bus.i_dmem_raddr = tbl[i].daddr;
            bus.i_mem_valid  = tbl[i].mv;    bus.i_mem_rdata  = tbl[i].md;
            @(negedge clk);
            check($sformatf("v%0d mem_ren", i),    64'(bus.o_mem_ren),    64'(tbl[i].e_mren));
            check($sformatf("v%0d mem_raddr", i),  bus.o_mem_raddr,       tbl[i].e_maddr);
            check($sformatf("v%0d imem_valid", i), 64'(bus.o_imem_valid), 64'(tbl[i].e_iv));
            check($sformatf("v%0d imem_rdata", i), bus.o_imem_rdata,      tbl[i].e_id);
            check($sformatf("v%0d dmem_valid", i), 64'(bus.o_dmem_valid), 64'(tbl[i].e_dv));
            check($sformatf("v%0d dmem_rdata", i), bus.o_dmem_rdata,      tbl[i].e_dd);
            check($sformatf("v%0d busy", i),       64'(bus.o_busy),       64'(tbl[i].e_busy));
        end

        // Random protocol phase: requesters obey one-in-flight, memory latency 1..3
        for (int r = 0; r < 2; r++) begin
            inflight[r] = 1'b0; req_addr[r] = '0; wait_cnt[r] = 0;
        end
        mem_pend = 1'b0; mem_addr = '0; mem_cnt = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            mv_now          = mem_pend && (mem_cnt == 0);
            bus.i_mem_valid = mv_now;
            bus.i_mem_rdata = mem_addr ^ c_MASK;
            bus.i_imem_ren  = 1'b0;
            bus.i_dmem_ren  = 1'b0;
            if (cyc < 380) begin
                if (!inflight[0] && ($urandom_range(0, 99) < 60)) begin
                    bus.i_imem_ren   = 1'b1;
                    bus.i_imem_raddr = {$urandom, $urandom};
                    inflight[0] = 1'b1; req_addr[0] = bus.i_imem_raddr; wait_cnt[0] = 0;
                end
                if (!inflight[1] && ($urandom_range(0, 99) < 60)) begin
                    bus.i_dmem_ren   = 1'b1;
                    bus.i_dmem_raddr = {$urandom, $urandom};
                    inflight[1] = 1'b1; req_addr[1] = bus.i_dmem_raddr; wait_cnt[1] = 0;
                end
            end
            @(negedge clk);
            check("rnd ren_while_busy",
                  64'(bus.o_mem_ren && bus.o_busy && !bus.i_mem_valid), 64'd0);
            if (bus.o_imem_valid) begin
                check("rnd imem_inflight", 64'(inflight[0]), 64'd1);
                check("rnd imem_rdata", bus.o_imem_rdata, req_addr[0] ^ c_MASK);
                inflight[0] = 1'b0;
            end
            if (bus.o_dmem_valid) begin
                check("rnd dmem_inflight", 64'(inflight[1]), 64'd1);
                check("rnd dmem_rdata", bus.o_dmem_rdata, req_addr[1] ^ c_MASK);
                inflight[1] = 1'b0;
            end
            if (mv_now) begin
                check("rnd valid_routed", 64'(bus.o_imem_valid ^ bus.o_dmem_valid), 64'd1);
                mem_pend = 1'b0;
            end
            if (mem_pend) mem_cnt--;
            if (bus.o_mem_ren) begin
                mem_pend = 1'b1;
                mem_addr = bus.o_mem_raddr;
                mem_cnt  = $urandom_range(0, 2);
            end
            for (int r = 0; r < 2; r++) begin
                if (inflight[r]) begin
                    wait_cnt[r]++;
                    if (wait_cnt[r] > 40) begin
                        check($sformatf("rnd timeout req%0d", r), 64'(wait_cnt[r]), 64'd40);
                        inflight[r] = 1'b0;
                    end
                end
            end
        end
        check("rnd drain imem", 64'(inflight[0]), 64'd0);
        check("rnd drain dmem", 64'(inflight[1]), 64'd0);
        check("rnd drain busy", 64'(bus.o_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
